knn_vote: RTL and testbench
===========================

# knn_vote

Downstream classification stage for the kNN accelerator. After a search, the pipeline sorter of the selected solver holds the HW_K nearest training-point indices, readable by rank through its SEL/DATA_OUT port. knn_vote reads the first k ranks and fetches each point's class label from an external label memory. It then builds a per-class vote histogram and reports the majority class and its vote count to the CPU-facing register interface.

## Interface
Parameters:
- HW_K, 10: number of ranks held by the sorter (max k); must be ≤ 255.
- IDX_W, 16: neighbour index / sorter select width.
- LABEL_W, 4: label width; number of classes N_CLASSES = 2**LABEL_W.
- CNT_W, 8: histogram counter and vote output width.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- start, input, 1: 1-cycle request to begin a vote; honoured only in IDLE.
- k, input, 8: neighbours to use; sampled on accepted start.
- SEL, output, IDX_W: rank select to the sorter read port.
- nn_idx, input, IDX_W: neighbour index for rank SEL; combinational, same cycle.
- label_addr, output, IDX_W: label memory address.
- label_rd, output, 1: label read strobe.
- label_data, input, LABEL_W: label, valid exactly 1 cycle after label_rd.
- busy, output, 1: high outside IDLE.
- done, output, 1: 1-cycle pulse when the result updates.
- class_out, output, LABEL_W: winning class.
- votes_out, output, CNT_W: votes of the winning class.

## Operation
- **Reset values:** all outputs 0; histogram cleared; FSM in IDLE.
- **Effective k (keff):** k=0 is treated as 1; k>HW_K is treated as HW_K.
- **IDLE:**
  - start=1: latch keff, clear all N_CLASSES counters in parallel, set rank counter r=0, go to READ.
  - start while busy is ignored; no queueing.
- **READ, one rank per cycle:**
  - SEL=r, label_addr=nn_idx, label_rd=1.
  - After r=keff-1, go to DRAIN; otherwise r++.
- **Accumulate:** every cycle where the previous cycle had label_rd=1, hist[label_data]++. This happens in READ cycles after the first and in DRAIN.
  - Counters cannot overflow, since keff ≤ HW_K ≤ 255.
- **DRAIN:** one cycle, takes the last accumulation; label_rd=0; go to SCAN.
- **SCAN:** one class c per cycle, c = 0..N_CLASSES-1.
  - best starts as (class 0, hist[0]).
  - Replace best only when hist[c] > best votes (strict), so ties resolve to the lowest class index.
  - After c=N_CLASSES-1, go to DONE.
- **DONE:** one cycle.
  - Register class_out/votes_out from best and pulse done=1.
  - Return to IDLE.
- **Output hold:** class_out/votes_out hold until the next DONE or rst.
- **Idle outputs:** SEL and label_addr are don't-care and driven 0 when label_rd=0.
- **rst mid-operation:** FSM to IDLE, counters cleared, outputs to 0. A label_data arriving the cycle after rst is discarded.

## Timing
- start accepted at cycle 0 → READ occupies cycles 1..keff.
- DRAIN at cycle keff+1.
- SCAN occupies cycles keff+2 .. keff+1+N_CLASSES.
- DONE state at cycle keff+2+N_CLASSES; done is high in that cycle.
- class_out/votes_out are valid in the same cycle as done.
- Total latency is keff+2+N_CLASSES cycles from the start cycle (28 for k=10, LABEL_W=4).
- busy is high from cycle 1 through the DONE cycle inclusive.
- A new start is accepted the cycle after done.
- Label memory requirement: registered 1-cycle read, fully pipelined (one read per cycle).

## Test plan
- **k=1:** nn_idx rank0=7, label[7]=3 → done at cycle 19, class_out=3, votes_out=1; label_rd high exactly 1 cycle with label_addr=7.
- **k=5:** labels by rank {2,5,2,9,2} → class_out=2, votes_out=3; done at cycle 23; label_rd high for 5 consecutive cycles with SEL=0..4.
- **Tie, k=4:** labels {6,1,6,1} → class_out=1, votes_out=2 (lowest index wins); all labels 15 with k=10 → class_out=15, votes_out=10.
- **Clamping:**
  - k=0 behaves as k=1.
  - k=200 with HW_K=10 reads only SEL=0..9; done at cycle 28.
- **start while busy:** a second start at cycle 5 is ignored: exactly one done pulse, result from the first k. A start in the cycle after done is accepted.
- **Reset mid-READ:** rst at cycle 3 → next cycle busy=0, done=0, class_out=0, votes_out=0. A following vote with k=3, labels {4,4,0} gives class_out=4, votes_out=2, with no contamination from the aborted run.

Source files
------------

// File: rtl/knn_vote.sv
// kNN majority vote: reads k sorted neighbour ranks, fetches labels,
// builds a per-class histogram and reports the winning class.
module knn_vote #(
  parameter int HW_K    = 10,
  parameter int IDX_W   = 16,
  parameter int LABEL_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         k,
  output logic [IDX_W-1:0]   SEL,
  input  logic [IDX_W-1:0]   nn_idx,
  output logic [IDX_W-1:0]   label_addr,
  output logic               label_rd,
  input  logic [LABEL_W-1:0] label_data,
  output logic               busy,
  output logic               done,
  output logic [LABEL_W-1:0] class_out,
  output logic [CNT_W-1:0]   votes_out
);

  localparam int N_CLASSES = 2 ** LABEL_W;
  localparam logic [7:0] KMAX = 8'(HW_K);
  localparam logic [LABEL_W-1:0] CLAST = LABEL_W'(N_CLASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_SCAN, S_DONE
  } state_t;

  state_t state, state_n;

  logic [7:0]         keff, keff_n, r;
  logic [LABEL_W-1:0] c, best_cls, nxt_cls;
  logic [CNT_W-1:0]   best_cnt, nxt_cnt;
  logic [CNT_W-1:0]   hist [N_CLASSES];
  logic               rd_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    label_rd   = 1'b0;
    SEL        = '0;
    label_addr = '0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_READ;
      end
      S_READ: begin
        label_rd   = 1'b1;
        SEL        = IDX_W'(r);
        label_addr = nn_idx;
        if (r == keff - 8'd1) state_n = S_DRAIN;
      end
      S_DRAIN: state_n = S_SCAN;
      S_SCAN:  if (c == CLAST) state_n = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    keff_n = k;
    unique case (1'b1)
      (k == 8'd0): keff_n = 8'd1;
      (k > KMAX):  keff_n = KMAX;
      default:     keff_n = k;
    endcase
  end

  // Strict compare keeps the lowest class index on ties.
  always_comb begin
    nxt_cls = best_cls;
    nxt_cnt = best_cnt;
    if (c == '0) begin
      nxt_cls = '0;
      nxt_cnt = hist[0];
    end else if (hist[c] > best_cnt) begin
      nxt_cls = c;
      nxt_cnt = hist[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keff      <= '0;
      r         <= '0;
      c         <= '0;
      rd_q      <= 1'b0;
      best_cls  <= '0;
      best_cnt  <= '0;
      class_out <= '0;
      votes_out <= '0;
      for (int i = 0; i < N_CLASSES; i++) hist[i] <= '0;
    end else begin
      rd_q <= label_rd;
      if (state == S_IDLE && start) begin
        keff <= keff_n;
        r    <= '0;
        c    <= '0;
        for (int i = 0; i < N_CLASSES; i++) hist[i] <= '0;
      end else if (rd_q) begin
        hist[label_data] <= hist[label_data] + 1'b1;
      end
      if (state == S_READ) r <= r + 8'd1;
      if (state == S_SCAN) begin
        c        <= c + 1'b1;
        best_cls <= nxt_cls;
        best_cnt <= nxt_cnt;
        if (c == CLAST) begin
          class_out <= nxt_cls;
          votes_out <= nxt_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote with a sorter table and a
// registered label memory model.
module tb_knn_vote;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  k;
  logic [15:0] SEL, nn_idx, label_addr;
  logic        label_rd;
  logic [3:0]  label_data;
  logic        busy, done;
  logic [3:0]  class_out;
  logic [7:0]  votes_out;

  logic [15:0] nn_tab  [256];
  logic [3:0]  lab_mem [256];

  int total = 0;
  int bad   = 0;

  knn_vote dut (
    .clk(clk), .rst(rst), .start(start), .k(k),
    .SEL(SEL), .nn_idx(nn_idx),
    .label_addr(label_addr), .label_rd(label_rd),
    .label_data(label_data), .busy(busy), .done(done),
    .class_out(class_out), .votes_out(votes_out)
  );

  always #5 clk = ~clk;

  assign nn_idx = nn_tab[SEL[7:0]];

  always @(posedge clk)
    if (label_rd) label_data <= lab_mem[label_addr[7:0]];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_run(input int base, input int n,
                         input logic [3:0] l0, input logic [3:0] l1,
                         input logic [3:0] l2, input logic [3:0] l3,
                         input logic [3:0] l4);
    logic [3:0] ls [5];
    ls = '{l0, l1, l2, l3, l4};
    for (int i = 0; i < n; i++) begin
      nn_tab[i] = 16'(base + i);
      lab_mem[base + i] = ls[i];
    end
  endtask

  // Launch a vote; counts cycles from the start cycle (0) to done.
  task automatic run_vote(input logic [7:0] k_in, input int xs,
                          output int cyc, output int rdn,
                          output int sel_err, output int busy_err,
                          output logic [15:0] addr0);
    cyc = 0; rdn = 0; sel_err = 0; busy_err = 0; addr0 = '0;
    @(posedge clk); #1;
    start = 1'b1;
    k     = k_in;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    forever begin
      @(negedge clk);
      if (label_rd) begin
        if (rdn == 0) addr0 = label_addr;
        if (SEL != 16'(rdn)) sel_err++;
        rdn++;
      end
      if (!busy) busy_err++;
      if (done || cyc > 100) break;
      @(posedge clk); #1;
      cyc++;
      start = (cyc == xs);
      k     = 8'd1;
    end
    start = 1'b0;
  endtask

  int cyc, rdn, se, be, extra;
  logic [15:0] a0;

  initial begin
    rst = 1'b1; start = 1'b0; k = '0;
    for (int i = 0; i < 256; i++) begin
      nn_tab[i]  = 16'd200;
      lab_mem[i] = 4'd2;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_class", class_out, 0);
    chk("rst_votes", votes_out, 0);
    chk("rst_rd",    label_rd, 0);

    nn_tab[0] = 16'd7; lab_mem[7] = 4'd3;
    run_vote(8'd1, 0, cyc, rdn, se, be, a0);
    chk("k1_cyc",   cyc, 19);
    chk("k1_class", class_out, 3);
    chk("k1_votes", votes_out, 1);
    chk("k1_rdn",   rdn, 1);
    chk("k1_addr",  a0, 7);
    chk("k1_busy",  be, 0);

    set_run(20, 5, 4'd2, 4'd5, 4'd2, 4'd9, 4'd2);
    run_vote(8'd5, 0, cyc, rdn, se, be, a0);
    chk("k5_cyc",   cyc, 23);
    chk("k5_class", class_out, 2);
    chk("k5_votes", votes_out, 3);
    chk("k5_rdn",   rdn, 5);
    chk("k5_sel",   se, 0);
    chk("k5_busy",  be, 0);

    set_run(30, 4, 4'd6, 4'd1, 4'd6, 4'd1, 4'd0);
    run_vote(8'd4, 0, cyc, rdn, se, be, a0);
    chk("tie_cyc",   cyc, 22);
    chk("tie_class", class_out, 1);
    chk("tie_votes", votes_out, 2);

    for (int i = 0; i < 10; i++) begin
      nn_tab[i] = 16'(40 + i);
      lab_mem[40 + i] = 4'd15;
    end
    run_vote(8'd10, 0, cyc, rdn, se, be, a0);
    chk("all15_cyc",   cyc, 28);
    chk("all15_class", class_out, 15);
    chk("all15_votes", votes_out, 10);

    nn_tab[0] = 16'd50; lab_mem[50] = 4'd8;
    run_vote(8'd0, 0, cyc, rdn, se, be, a0);
    chk("k0_cyc",   cyc, 19);
    chk("k0_class", class_out, 8);
    chk("k0_votes", votes_out, 1);
    chk("k0_rdn",   rdn, 1);

    // Ranks beyond 9 would pull label 2 from index 70.
    for (int i = 0; i < 256; i++) nn_tab[i] = 16'd70;
    lab_mem[70] = 4'd2;
    set_run(60, 5, 4'd3, 4'd3, 4'd7, 4'd7, 4'd7);
    for (int i = 5; i < 9; i++) begin
      nn_tab[i] = 16'(60 + i);
      lab_mem[60 + i] = 4'd1;
    end
    nn_tab[9] = 16'd69; lab_mem[69] = 4'd5;
    run_vote(8'd200, 0, cyc, rdn, se, be, a0);
    chk("clamp_cyc",   cyc, 28);
    chk("clamp_rdn",   rdn, 10);
    chk("clamp_sel",   se, 0);
    chk("clamp_class", class_out, 1);
    chk("clamp_votes", votes_out, 4);

    set_run(20, 5, 4'd2, 4'd5, 4'd2, 4'd9, 4'd2);
    run_vote(8'd5, 5, cyc, rdn, se, be, a0);
    chk("busy_cyc",   cyc, 23);
    chk("busy_class", class_out, 2);
    chk("busy_votes", votes_out, 3);
    extra = 0;
    be = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) extra++;
      if (busy) be++;
    end
    chk("busy_nodone", extra, 0);
    chk("busy_idle",   be, 0);

    for (int i = 0; i < 5; i++) begin
      nn_tab[i] = 16'(80 + i);
      lab_mem[80 + i] = 4'd0;
    end
    @(posedge clk); #1;
    start = 1'b1; k = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_busy",  busy, 0);
    chk("mid_done",  done, 0);
    chk("mid_class", class_out, 0);
    chk("mid_votes", votes_out, 0);

    set_run(90, 3, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0);
    run_vote(8'd3, 0, cyc, rdn, se, be, a0);
    chk("post_cyc",   cyc, 21);
    chk("post_class", class_out, 4);
    chk("post_votes", votes_out, 2);
    chk("post_rdn",   rdn, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
